ats21_instr_rx: RTL and testbench
=================================

Name: ats21_instr_rx

Overview:
Client-side instruction receiver and decoder at the front of ATS21. It captures the two-beat, 16-bit-per-beat instruction stream from clients A and B on a shared req strobe. It reassembles each 32-bit instruction, decodes its fields and rejects NOPs and illegal opcodes. Accepted instructions are queued in a small FIFO and presented one at a time to the ATS21 core over a valid/ready handshake.

Parameters:
DEPTH, 4, decoded-instruction FIFO entries; power of 2, >= 2

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  1  client request strobe; high on beat 1 only
ctrlA  input  16  client A word: beat 1 = instr[31:16], beat 2 = instr[15:0]
ctrlB  input  16  client B word, same framing as ctrlA
ready  output  1  receiver can accept a request this cycle
stat  output  2  one-cycle status: 00 ok, 01 request dropped, 10 illegal opcode, 11 both
out_valid  output  1  decoded instruction at FIFO head
out_ready  input  1  core accepts head entry
out_client  output  1  0 = A, 1 = B
out_opcode  output  3  instr[31:29]
out_clk_sel  output  4  clock number
out_id  output  5  alarm/timer number (opcodes 101/110/111), else 0
out_flag  output  1  instr[23] (repeat / enable), 0 for 001 and 011
out_rate  output  2  instr[23:22] for opcode 001, else 0
out_mode  output  5  instr[28:24] for opcode 011, else 0
out_value  output  16  instr[15:0] (time/alarm/interval), 0 for 010/011/111

Behaviour:
- Reset (reset=0 at a clk edge): FSM to IDLE; FIFO flushed; any partial capture discarded.
  - Reset values: ready=0 during reset, stat=00, out_valid=0, all out_* fields 0.
- FSM states: IDLE, BEAT2.
- IDLE:
  - ready = (count <= DEPTH-2), so a whole A+B pair always fits.
  - If req=1 and ready=1: latch ctrlA and ctrlB as the upper halves, then go to BEAT2.
  - If req=1 and ready=0: nothing is latched, stay in IDLE, stat=01 on the next cycle.
- BEAT2:
  - ready=0.
  - Latch ctrlA/ctrlB as the lower halves, and the req value is ignored.
  - Assemble instrA and instrB, then return to IDLE.
  - req may be high again on the very next cycle (back-to-back requests at a 2-cycle spacing are legal).
- Per-client classification at BEAT2:
  - Opcode 000 is a NOP for that client and is silently discarded.
  - Opcode 100 is illegal: discarded, and stat=10 on the next cycle.
  - Opcodes 001, 010, 011, 101, 110 and 111 are decoded and pushed.
- Push order:
  - A before B in the same cycle, so 0, 1 or 2 pushes per cycle.
  - The write pointer advances by the push count.
  - Pointers wrap modulo DEPTH.
- Decode of the upper half U = instr[31:16]:
  - Opcodes 001/010: clk_sel = U[12:9].
  - Opcodes 101/110: clk_sel = U[3:0], id = U[12:8].
  - Opcode 111: id = U[12:8], flag = U[7].
  - Opcode 010: flag = U[7].
  - Unused fields are forced to 0.
- stat timing:
  - Registered; asserted exactly one cycle, on the cycle after BEAT2 (or after the dropped req); otherwise 00.
  - If both conditions occur in the same cycle, stat=11.
- Output handshake:
  - out_valid = count != 0; out_* fields are driven directly from the head entry.
  - A pop occurs when out_valid && out_ready; the head must stay stable while out_valid=1 and out_ready=0.
  - Simultaneous pop and push in the same cycle is legal: count = count + pushes − pop.
  - count never exceeds DEPTH; admission at IDLE guarantees this.
- Full/empty:
  - With count = DEPTH-1 or DEPTH, ready=0.
  - An empty FIFO with out_ready=1 pops nothing.
- Latency: a request at cycle T has out_valid=1 at T+2 if the FIFO was empty (client A entry first).

Test Plan:
- Reset, then req with ctrlA=0x2000/0x0000 and ctrlB=0x2240/0x0000, out_ready=1 -> at T+2 the A entry is presented (opcode 001, clk_sel 0, rate 00); at T+3 the B entry (clk_sel 1, rate 01); stat=00.
- ctrlA=0xA080/0x0025, ctrlB=0x0000/0x0000 -> one entry only: client A, opcode 101, id 0, flag 1, clk_sel 0, value 0x0025; B is dropped silently.
- ctrlA=0xC102/0x0010, ctrlB=0x8000/0x1234 -> one entry: A, opcode 110, id 1, clk_sel 2, value 0x0010; stat=10 for exactly one cycle.
- out_ready=0, DEPTH=4, two A+B requests back-to-back -> count=4 and ready=0; a third req gives stat=01 and count stays 4; raising out_ready drains the four entries in order A1, B1, A2, B2.
- Hold out_ready=1 with a new request arriving while the FIFO is draining -> no entry lost or duplicated and order is preserved.
- Assert reset in BEAT2 -> no entry is pushed, out_valid=0, ready returns to 1 after reset deasserts.

Source files
------------

// File: rtl/ats21_instr_rx_if.sv
// Client-side instruction receiver bus: request capture inputs, status,
// and the decoded-instruction valid/ready output towards the ATS21 core.
interface ats21_instr_rx_if;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic        out_valid;
    logic        out_ready;
    logic        out_client;
    logic [2:0]  out_opcode;
    logic [3:0]  out_clk_sel;
    logic [4:0]  out_id;
    logic        out_flag;
    logic [1:0]  out_rate;
    logic [4:0]  out_mode;
    logic [15:0] out_value;

    // Receiver side
    modport slave (
        input  req, ctrlA, ctrlB, out_ready,
        output ready, stat, out_valid, out_client, out_opcode, out_clk_sel,
               out_id, out_flag, out_rate, out_mode, out_value
    );

    // Client / core side
    modport master (
        output req, ctrlA, ctrlB, out_ready,
        input  ready, stat, out_valid, out_client, out_opcode, out_clk_sel,
               out_id, out_flag, out_rate, out_mode, out_value
    );
endinterface

// File: rtl/ats21_instr_rx.sv
// ATS21 instruction receiver: captures two-beat A/B instruction words,
// decodes them, drops NOPs and illegal opcodes, and queues decoded
// entries in a small FIFO presented over a valid/ready handshake.
module ats21_instr_rx #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    ats21_instr_rx_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, BEAT2} state_t;

    typedef struct packed {
        logic        client;
        logic [2:0]  opcode;
        logic [3:0]  clk_sel;
        logic [4:0]  id;
        logic        flag;
        logic [1:0]  rate;
        logic [4:0]  mode;
        logic [15:0] value;
    } entry_t;

    state_t        state;
    logic [15:0]   upper_a;
    logic [15:0]   upper_b;
    logic [1:0]    stat_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];

    logic          can_accept;
    logic          drop;
    logic          illegal;
    logic          push_a;
    logic          push_b;
    logic          pop;
    logic [CW-1:0] n_push;
    logic [2:0]    op_a;
    logic [2:0]    op_b;
    entry_t        entry_a;
    entry_t        entry_b;
    entry_t        head;
    logic          unused_bits;

    // Field decode from the upper half; fields an opcode does not use stay 0.
    // hi5 = U[12:8], mid2 = U[7:6], lo4 = U[3:0].
    function automatic entry_t decode(input logic client, input logic [2:0] op,
                                      input logic [4:0] hi5, input logic [1:0] mid2,
                                      input logic [3:0] lo4, input logic [15:0] lower);
        entry_t e;
        e        = '0;
        e.client = client;
        e.opcode = op;
        case (op)
            3'b001: begin
                e.clk_sel = hi5[4:1];
                e.rate    = mid2;
                e.value   = lower;
            end
            3'b010: begin
                e.clk_sel = hi5[4:1];
                e.flag    = mid2[1];
            end
            3'b011: begin
                e.mode = hi5;
            end
            3'b101, 3'b110: begin
                e.clk_sel = lo4;
                e.id      = hi5;
                e.flag    = mid2[1];
                e.value   = lower;
            end
            3'b111: begin
                e.id   = hi5;
                e.flag = mid2[1];
            end
            default: ;
        endcase
        return e;
    endfunction

    // U[5:4] carries no field for any opcode
    assign unused_bits = ^{upper_a[5:4], upper_b[5:4]};

    // Admission, classification and push/pop decisions for this cycle
    always_comb begin
        can_accept = (count <= CW'(DEPTH - 2));
        op_a       = upper_a[15:13];
        op_b       = upper_b[15:13];
        push_a     = reset && (state == BEAT2) && (op_a != 3'b000) && (op_a != 3'b100);
        push_b     = reset && (state == BEAT2) && (op_b != 3'b000) && (op_b != 3'b100);
        illegal    = (state == BEAT2) && ((op_a == 3'b100) || (op_b == 3'b100));
        drop       = (state == IDLE) && bus.req && !can_accept;
        pop        = (count != '0) && bus.out_ready;
        n_push     = CW'(push_a) + CW'(push_b);
        entry_a    = decode(1'b0, op_a, upper_a[12:8], upper_a[7:6], upper_a[3:0], bus.ctrlA);
        entry_b    = decode(1'b1, op_b, upper_b[12:8], upper_b[7:6], upper_b[3:0], bus.ctrlB);
        head       = (count != '0) ? mem[rd_ptr] : '0;
    end

    // Two-state capture FSM with registered one-cycle status
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            stat_q <= 2'b00;
        end else begin
            stat_q <= {illegal, drop};
            case (state)
                IDLE:    if (bus.req && can_accept) state <= BEAT2;
                BEAT2:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Upper-half capture on an accepted beat 1
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.req && can_accept) begin
            upper_a <= bus.ctrlA;
            upper_b <= bus.ctrlB;
        end
    end

    // FIFO pointers and occupancy; A is written before B
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + n_push - CW'(pop);
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= entry_a;
        if (push_b) mem[push_a ? wr_ptr + PW'(1) : wr_ptr] <= entry_b;
    end

    assign bus.ready       = reset && (state == IDLE) && can_accept;
    assign bus.stat        = stat_q;
    assign bus.out_valid   = (count != '0);
    assign bus.out_client  = head.client;
    assign bus.out_opcode  = head.opcode;
    assign bus.out_clk_sel = head.clk_sel;
    assign bus.out_id      = head.id;
    assign bus.out_flag    = head.flag;
    assign bus.out_rate    = head.rate;
    assign bus.out_mode    = head.mode;
    assign bus.out_value   = head.value;
endmodule

// File: tb/tb_ats21_instr_rx.sv
// Self-checking bench for ats21_instr_rx: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_ats21_instr_rx;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        client;
        logic [2:0]  opcode;
        logic [3:0]  clk_sel;
        logic [4:0]  id;
        logic        flag;
        logic [1:0]  rate;
        logic [4:0]  mode;
        logic [15:0] value;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failures = 0;

    ats21_instr_rx_if bus();

    ats21_instr_rx #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state
    ent_t        q[$];
    logic        pending = 1'b0;
    logic [15:0] ua, ub;
    logic [1:0]  m_stat = 2'b00;

    function automatic ent_t model_decode(input logic client, input logic [15:0] u,
                                          input logic [15:0] lower);
        ent_t e;
        int   op;
        op        = int'(u[15:13]);
        e.client  = client;
        e.opcode  = u[15:13];
        e.clk_sel = (op == 1 || op == 2) ? u[12:9] : (op == 5 || op == 6) ? u[3:0] : 4'd0;
        e.id      = (op >= 5) ? u[12:8] : 5'd0;
        e.flag    = (op == 2 || op >= 5) ? u[7] : 1'b0;
        e.rate    = (op == 1) ? u[7:6] : 2'd0;
        e.mode    = (op == 3) ? u[12:8] : 5'd0;
        e.value   = (op == 1 || op == 5 || op == 6) ? lower : 16'd0;
        return e;
    endfunction

    function automatic ent_t dut_head();
        return {bus.out_client, bus.out_opcode, bus.out_clk_sel, bus.out_id,
                bus.out_flag, bus.out_rate, bus.out_mode, bus.out_value};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_rdy;
        exp_rdy = rst_n && !pending && (q.size() <= DEPTH - 2);
        check("ready", 64'(bus.ready), 64'(exp_rdy));
        check("stat", 64'(bus.stat), 64'(m_stat));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) check("head", 64'(dut_head()), 64'(q[0]));
    endtask

    task automatic model_proc(input logic client, input logic [15:0] u,
                              input logic [15:0] lower, inout logic [1:0] ns);
        if (u[15:13] == 3'b100) ns[1] = 1'b1;
        else if (u[15:13] != 3'b000) q.push_back(model_decode(client, u, lower));
    endtask

    task automatic model_step();
        logic       rdy;
        logic [1:0] ns;
        if (!rst_n) begin
            q.delete();
            pending = 1'b0;
            m_stat  = 2'b00;
            return;
        end
        rdy = !pending && (q.size() <= DEPTH - 2);
        ns  = 2'b00;
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (pending) begin
            model_proc(1'b0, ua, bus.ctrlA, ns);
            model_proc(1'b1, ub, bus.ctrlB, ns);
            pending = 1'b0;
        end else if (bus.req) begin
            if (rdy) begin
                ua      = bus.ctrlA;
                ub      = bus.ctrlB;
                pending = 1'b1;
            end else begin
                ns[0] = 1'b1;
            end
        end
        m_stat = ns;
    endtask

    task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic o);
        bus.req       = r;
        bus.ctrlA     = a;
        bus.ctrlB     = b;
        bus.out_ready = o;
        #3;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = 1'b0;
        bus.ctrlA     = '0;
        bus.ctrlB     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_stat", 64'(bus.stat), 64'd0);
        check("rst_fields", 64'(dut_head()), 64'd0);
        tick();
        rst_n = 1'b1;

        // Two opcode-001 entries, A then B
        drive(1'b1, 16'h2000, 16'h2240, 1'b1); tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t1_a_valid", 64'(bus.out_valid), 64'd1);
        check("t1_a_head", 64'({bus.out_client, bus.out_opcode, bus.out_clk_sel, bus.out_rate}),
              64'({1'b0, 3'b001, 4'd0, 2'b00}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t1_b_head", 64'({bus.out_client, bus.out_opcode, bus.out_clk_sel, bus.out_rate}),
              64'({1'b1, 3'b001, 4'd1, 2'b01}));
        check("t1_stat", 64'(bus.stat), 64'd0);
        tick();

        // Opcode 101 from A, NOP from B
        drive(1'b1, 16'hA080, 16'h0000, 1'b1); tick();
        drive(1'b0, 16'h0025, 16'h0000, 1'b1); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("t2_head", 64'(dut_head()),
              64'({1'b0, 3'b101, 4'd0, 5'd0, 1'b1, 2'd0, 5'd0, 16'h0025}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t2_only_one", 64'(bus.out_valid), 64'd0);
        tick();

        // Opcode 110 from A, illegal from B
        drive(1'b1, 16'hC102, 16'h8000, 1'b1); tick();
        drive(1'b0, 16'h0010, 16'h1234, 1'b1); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t3_stat", 64'(bus.stat), 64'b10);
        check("t3_head", 64'(dut_head()),
              64'({1'b0, 3'b110, 4'd2, 5'd1, 1'b0, 2'd0, 5'd0, 16'h0010}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t3_stat_clear", 64'(bus.stat), 64'b00);
        check("t3_drained", 64'(bus.out_valid), 64'd0);
        tick();

        // Fill to DEPTH, overflow request is dropped, then drain in order
        drive(1'b1, 16'h2000, 16'h4000, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0); tick();
        drive(1'b1, 16'h6000, 16'hE000, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0); tick();
        drive(1'b1, 16'h2000, 16'h2000, 1'b0);
        check("t4_full_ready", 64'(bus.ready), 64'd0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t4_drop_stat", 64'(bus.stat), 64'b01);
        check("t4_d0", 64'({bus.out_client, bus.out_opcode}), 64'({1'b0, 3'b001}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t4_d1", 64'({bus.out_client, bus.out_opcode}), 64'({1'b1, 3'b010}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t4_d2", 64'({bus.out_client, bus.out_opcode}), 64'({1'b0, 3'b011}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t4_d3", 64'({bus.out_client, bus.out_opcode}), 64'({1'b1, 3'b111}));
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("t4_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // New request arriving while draining
        drive(1'b1, 16'h2200, 16'h4400, 1'b0); tick();
        drive(1'b0, 16'h0001, 16'h0002, 1'b1); tick();
        drive(1'b1, 16'hA0C3, 16'hE1C0, 1'b1); tick();
        drive(1'b0, 16'h0055, 16'h0066, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1); tick();
        end

        // Reset while in BEAT2
        drive(1'b1, 16'hA080, 16'h2000, 1'b0); tick();
        rst_n = 1'b0;
        drive(1'b0, 16'h0025, 16'h0000, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("t6_ready", 64'(bus.ready), 64'd1);
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive(($urandom_range(0, 99) < 55), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), ($urandom_range(0, 99) < 60));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
